zbuffer_pixel_writer: RTL and testbench

//  Fragment-to-frame-buffer write stage, directly upstream of frame_buffers_datapath rasterizer ports.
//  Per frame: clears the target buffer, then accepts fragments over a valid/ready handshake.

---
 rtl/zbuffer_pixel_writer.sv | 169 ++++++++++++++++
 tb/tb_zbuffer_pixel_writer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/zbuffer_pixel_writer.sv
// Purpose: per-frame clear of the target buffer, then per-fragment z-test and write (ZBUF_DEPTH_TEST_EN enables the read/test path).
// Latency: clear = VERT*HORIZ write cycles; fragment write 2 cycles after accept with depth test, 1 cycle without.
// Backpressure: o_frag_ready is high only in ACCEPT, so one fragment is in flight; throughput 1/3 (depth test) or 1/2.
module zbuffer_pixel_writer #(
    parameter int VERT_RESOLUTION  = 60,
    parameter int HORIZ_RESOLUTION = 80,
    parameter int COLOR_DEPTH      = 12,
    parameter int Z_DEPTH          = 2,
    parameter logic [COLOR_DEPTH-1:0] CLEAR_COLOR = '0
) (
    input  logic                                i_sys_clk,
    input  logic                                i_sys_rst,
    input  logic                                i_frame_start,
    input  logic                                i_frame_end,
    input  logic                                i_frag_valid,
    output logic                                o_frag_ready,
    input  logic [$clog2(VERT_RESOLUTION)-1:0]  i_frag_vert,
    input  logic [$clog2(HORIZ_RESOLUTION)-1:0] i_frag_horiz,
    input  logic [COLOR_DEPTH-1:0]              i_frag_color,
    input  logic [Z_DEPTH-1:0]                  i_frag_z,
    input  logic [COLOR_DEPTH+Z_DEPTH-1:0]      i_read_pixel_data,
    output logic [$clog2(VERT_RESOLUTION)-1:0]  o_vert_addr,
    output logic [$clog2(HORIZ_RESOLUTION)-1:0] o_horiz_addr,
    output logic                                o_write_en,
    output logic [COLOR_DEPTH+Z_DEPTH-1:0]      o_write_pixel_data,
    output logic                                o_busy,
    output logic                                o_frame_done
);

    localparam int VW = $clog2(VERT_RESOLUTION);
    localparam int HW = $clog2(HORIZ_RESOLUTION);
    localparam int PW = COLOR_DEPTH + Z_DEPTH;

    localparam logic [VW-1:0] V_LAST  = VW'(VERT_RESOLUTION - 1);
    localparam logic [HW-1:0] H_LAST  = HW'(HORIZ_RESOLUTION - 1);
    localparam logic [VW:0]   V_LIMIT = (VW + 1)'(VERT_RESOLUTION);
    localparam logic [HW:0]   H_LIMIT = (HW + 1)'(HORIZ_RESOLUTION);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_CLEAR  = 3'd1;
    localparam logic [2:0] ST_ACCEPT = 3'd2;
`ifdef ZBUF_DEPTH_TEST_EN
    localparam logic [2:0] ST_READ   = 3'd3;
    localparam logic [2:0] ST_TEST   = 3'd4;
`else
    localparam logic [2:0] ST_WRITE  = 3'd5;
`endif
    localparam logic [2:0] ST_DONE   = 3'd6;

    logic [2:0]             state;
    // Address registers double as the clear sweep counters.
    logic [VW-1:0]          vert_addr;
    logic [HW-1:0]          horiz_addr;
    logic [COLOR_DEPTH-1:0] frag_color;
    logic [Z_DEPTH-1:0]     frag_z;
    logic                   frag_in_range;
    logic                   end_pending;
    logic                   end_seen;
    logic                   in_range;

    assign end_seen = end_pending | i_frame_end;
    assign in_range = ({1'b0, i_frag_vert} < V_LIMIT) && ({1'b0, i_frag_horiz} < H_LIMIT);

`ifndef ZBUF_DEPTH_TEST_EN
    // Read data only feeds the depth compare, which is absent in this build.
    logic unused_read;
    assign unused_read = ^i_read_pixel_data;
`endif

    // Frame sequencing: clear sweep, fragment accept/retire, end-of-frame handling.
    always_ff @(posedge i_sys_clk) begin
        if (i_sys_rst) begin
            state         <= ST_IDLE;
            vert_addr     <= '0;
            horiz_addr    <= '0;
            frag_color    <= '0;
            frag_z        <= '0;
            frag_in_range <= 1'b0;
            end_pending   <= 1'b0;
        end else begin
            if (state == ST_DONE) begin
                end_pending <= 1'b0;
            end else if (i_frame_end && state != ST_IDLE) begin
                end_pending <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (i_frame_start) begin
                        state      <= ST_CLEAR;
                        vert_addr  <= '0;
                        horiz_addr <= '0;
                    end
                end
                ST_CLEAR: begin
                    if (horiz_addr == H_LAST) begin
                        horiz_addr <= '0;
                        if (vert_addr == V_LAST) begin
                            state <= ST_ACCEPT;
                        end else begin
                            vert_addr <= vert_addr + 1'b1;
                        end
                    end else begin
                        horiz_addr <= horiz_addr + 1'b1;
                    end
                end
                ST_ACCEPT: begin
                    // A valid fragment wins over a pending end; the end completes next idle ACCEPT.
                    if (i_frag_valid) begin
                        vert_addr     <= i_frag_vert;
                        horiz_addr    <= i_frag_horiz;
                        frag_color    <= i_frag_color;
                        frag_z        <= i_frag_z;
                        frag_in_range <= in_range;
`ifdef ZBUF_DEPTH_TEST_EN
                        state         <= ST_READ;
`else
                        state         <= ST_WRITE;
`endif
                    end else if (end_seen) begin
                        state <= ST_DONE;
                    end
                end
`ifdef ZBUF_DEPTH_TEST_EN
                ST_READ:  state <= ST_TEST;
                ST_TEST:  state <= ST_ACCEPT;
`else
                ST_WRITE: state <= ST_ACCEPT;
`endif
                ST_DONE:  state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    // Write port: clear word during the sweep, fragment word when it retires.
    always_comb begin
        o_write_en         = 1'b0;
        o_write_pixel_data = '0;
        case (state)
            ST_CLEAR: begin
                o_write_en         = 1'b1;
                o_write_pixel_data = {CLEAR_COLOR, {Z_DEPTH{1'b1}}};
            end
`ifdef ZBUF_DEPTH_TEST_EN
            ST_TEST: begin
                o_write_pixel_data = {frag_color, frag_z};
                o_write_en         = frag_in_range && (frag_z < i_read_pixel_data[Z_DEPTH-1:0]);
            end
`else
            ST_WRITE: begin
                o_write_pixel_data = {frag_color, frag_z};
                o_write_en         = frag_in_range;
            end
`endif
            default: begin
                o_write_en         = 1'b0;
                o_write_pixel_data = PW'(0);
            end
        endcase
    end

    assign o_vert_addr  = vert_addr;
    assign o_horiz_addr = horiz_addr;
    assign o_frag_ready = (state == ST_ACCEPT);
    assign o_busy       = (state != ST_IDLE);
    assign o_frame_done = (state == ST_DONE);

endmodule

// File: tb/tb_zbuffer_pixel_writer.sv
// Directed bench for zbuffer_pixel_writer: clear sweep, fragment table, end race, mid-clear reset.
// Expectations follow the build: depth-test path when ZBUF_DEPTH_TEST_EN is defined, unconditional writes otherwise.
// A behavioural frame-buffer RAM with 1-cycle synchronous read sits on the address/write ports.
module tb_zbuffer_pixel_writer;

    logic        clk;
    logic        rst;
    logic        frame_start;
    logic        frame_end;
    logic        frag_valid;
    logic        frag_ready;
    logic [5:0]  frag_vert;
    logic [6:0]  frag_horiz;
    logic [11:0] frag_color;
    logic [1:0]  frag_z;
    logic [13:0] read_data;
    logic [5:0]  vert_addr;
    logic [6:0]  horiz_addr;
    logic        write_en;
    logic [13:0] write_data;
    logic        busy;
    logic        frame_done;

    int n_cmp = 0;
    int n_err = 0;

    logic [13:0] mem [0:63][0:127];

    zbuffer_pixel_writer dut (
        .i_sys_clk          (clk),
        .i_sys_rst          (rst),
        .i_frame_start      (frame_start),
        .i_frame_end        (frame_end),
        .i_frag_valid       (frag_valid),
        .o_frag_ready       (frag_ready),
        .i_frag_vert        (frag_vert),
        .i_frag_horiz       (frag_horiz),
        .i_frag_color       (frag_color),
        .i_frag_z           (frag_z),
        .i_read_pixel_data  (read_data),
        .o_vert_addr        (vert_addr),
        .o_horiz_addr       (horiz_addr),
        .o_write_en         (write_en),
        .o_write_pixel_data (write_data),
        .o_busy             (busy),
        .o_frame_done       (frame_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Frame buffer model: write and synchronous read share the address.
    always @(posedge clk) begin
        if (write_en) mem[vert_addr][horiz_addr] <= write_data;
        read_data <= mem[vert_addr][horiz_addr];
    end

    typedef struct {
        logic [5:0]  v;
        logic [6:0]  h;
        logic [11:0] c;
        logic [1:0]  z;
        logic        we_dt;
        logic        we_nodt;
    } vec_t;

    vec_t tbl [9];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, " write_en"}, {31'd0, write_en}, 32'd0);
        chk({name, " ready"}, {31'd0, frag_ready}, 32'd0);
        chk({name, " busy"}, {31'd0, busy}, 32'd0);
        chk({name, " done"}, {31'd0, frame_done}, 32'd0);
        chk({name, " addr"}, {19'd0, vert_addr, horiz_addr}, 32'd0);
        chk({name, " data"}, {18'd0, write_data}, 32'd0);
    endtask

    // Issues frame_start from IDLE and follows the whole clear sweep.
    task automatic run_clear(input string name);
        int writes = 0;
        int bad_data = 0;
        int bad_addr = 0;
        int guard = 0;
        logic [5:0] ev = '0;
        logic [6:0] eh = '0;
        logic [5:0] last_v = '0;
        logic [6:0] last_h = '0;
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        while (!frag_ready && guard < 5000) begin
            if (write_en) begin
                writes++;
                if (write_data !== 14'h0003) bad_data++;
                if (vert_addr !== ev || horiz_addr !== eh) bad_addr++;
                last_v = vert_addr;
                last_h = horiz_addr;
                if (eh == 7'd79) begin
                    eh = 7'd0;
                    ev = ev + 6'd1;
                end else begin
                    eh = eh + 7'd1;
                end
            end else begin
                bad_data++;
            end
            guard++;
            step();
        end
        chk({name, " write count"}, writes, 32'd4800);
        chk({name, " bad data/gaps"}, bad_data, 32'd0);
        chk({name, " addr order"}, bad_addr, 32'd0);
        chk({name, " last addr"}, {19'd0, last_v, last_h}, {19'd0, 6'd59, 7'd79});
        chk({name, " ready after"}, {31'd0, frag_ready}, 32'd1);
        chk({name, " write_en off"}, {31'd0, write_en}, 32'd0);
    endtask

    // Presents one fragment in ACCEPT and checks its retirement cycle.
    task automatic apply_frag(input string name, input logic [5:0] v, input logic [6:0] h,
                              input logic [11:0] c, input logic [1:0] z, input logic exp_we);
        chk({name, " ready before"}, {31'd0, frag_ready}, 32'd1);
        frag_valid = 1'b1;
        frag_vert  = v;
        frag_horiz = h;
        frag_color = c;
        frag_z     = z;
        step();
        frag_valid = 1'b0;
        chk({name, " ready drop"}, {31'd0, frag_ready}, 32'd0);
`ifdef ZBUF_DEPTH_TEST_EN
        chk({name, " no write in read"}, {31'd0, write_en}, 32'd0);
        step();
        chk({name, " ready drop 2"}, {31'd0, frag_ready}, 32'd0);
`endif
        chk({name, " write_en"}, {31'd0, write_en}, {31'd0, exp_we});
        chk({name, " addr"}, {19'd0, vert_addr, horiz_addr}, {19'd0, v, h});
        if (exp_we) chk({name, " data"}, {18'd0, write_data}, {18'd0, c, z});
        step();
    endtask

    initial begin
        rst         = 1'b1;
        frame_start = 1'b0;
        frame_end   = 1'b0;
        frag_valid  = 1'b0;
        frag_vert   = '0;
        frag_horiz  = '0;
        frag_color  = '0;
        frag_z      = '0;

        // Stored z after clear is 3; rows track the stored z through the sequence.
        tbl[0] = '{6'd10, 7'd20, 12'hFFF, 2'd1, 1'b1, 1'b1};
        tbl[1] = '{6'd10, 7'd20, 12'hABC, 2'd2, 1'b0, 1'b1};
        tbl[2] = '{6'd10, 7'd20, 12'h123, 2'd1, 1'b0, 1'b1};
        tbl[3] = '{6'd10, 7'd20, 12'h456, 2'd0, 1'b1, 1'b1};
        tbl[4] = '{6'd60, 7'd5,  12'h777, 2'd0, 1'b0, 1'b0};
        tbl[5] = '{6'd5,  7'd80, 12'h111, 2'd0, 1'b0, 1'b0};
        tbl[6] = '{6'd59, 7'd79, 12'h222, 2'd3, 1'b0, 1'b1};
        tbl[7] = '{6'd59, 7'd79, 12'h333, 2'd2, 1'b1, 1'b1};
        tbl[8] = '{6'd0,  7'd0,  12'h0AA, 2'd0, 1'b1, 1'b1};

        step();
        step();
        chk_all_zero("reset");
        rst = 1'b0;
        step();
        chk("idle busy", {31'd0, busy}, 32'd0);

        // frame_end while IDLE must not leave a pending end behind.
        frame_end = 1'b1;
        step();
        frame_end = 1'b0;
        chk("idle end ignored", {31'd0, busy}, 32'd0);

        run_clear("clear1");
        step();
        step();
        chk("accept no stale end", {31'd0, frame_done}, 32'd0);
        chk("accept holds ready", {31'd0, frag_ready}, 32'd1);

        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        chk("start ignored ready", {31'd0, frag_ready}, 32'd1);
        chk("start ignored write", {31'd0, write_en}, 32'd0);

        for (int i = 0; i < 9; i++) begin
`ifdef ZBUF_DEPTH_TEST_EN
            apply_frag($sformatf("vec%0d", i), tbl[i].v, tbl[i].h, tbl[i].c, tbl[i].z, tbl[i].we_dt);
`else
            apply_frag($sformatf("vec%0d", i), tbl[i].v, tbl[i].h, tbl[i].c, tbl[i].z, tbl[i].we_nodt);
`endif
        end
        chk("ram (10,20)", {18'd0, mem[10][20]}, {18'd0, 12'h456, 2'd0});
        chk("ram (59,79)", {18'd0, mem[59][79]}, {18'd0, 12'h333, 2'd2});
        chk("ram (0,1) cleared", {18'd0, mem[0][1]}, 32'h3);

        // End race: frame_end together with a valid fragment.
        frag_valid = 1'b1;
        frag_vert  = 6'd3;
        frag_horiz = 7'd3;
        frag_color = 12'h5A5;
        frag_z     = 2'd0;
        frame_end  = 1'b1;
        step();
        frag_valid = 1'b0;
        frame_end  = 1'b0;
        chk("race no early done", {31'd0, frame_done}, 32'd0);
`ifdef ZBUF_DEPTH_TEST_EN
        step();
`endif
        chk("race frag write", {31'd0, write_en}, 32'd1);
        chk("race frag data", {18'd0, write_data}, {18'd0, 12'h5A5, 2'd0});
        step();
        chk("race back to accept", {31'd0, frag_ready}, 32'd1);
        chk("race done not yet", {31'd0, frame_done}, 32'd0);
        step();
        chk("race done pulse", {31'd0, frame_done}, 32'd1);
        chk("race busy in done", {31'd0, busy}, 32'd1);
        step();
        chk("race done one cycle", {31'd0, frame_done}, 32'd0);
        chk("race idle", {31'd0, busy}, 32'd0);

        // Reset at the 100th clear write.
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        for (int i = 0; i < 99; i++) step();
        chk("rst mid write_en", {31'd0, write_en}, 32'd1);
        chk("rst mid addr", {19'd0, vert_addr, horiz_addr}, {19'd0, 6'd1, 7'd19});
        rst = 1'b1;
        step();
        chk_all_zero("mid reset");
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("post reset no done", {30'd0, frame_done, busy}, 32'd0);
        end

        run_clear("clear2");
        apply_frag("after restart", 6'd0, 7'd1, 12'hABC, 2'd0, 1'b1);
        frame_end = 1'b1;
        step();
        frame_end = 1'b0;
        chk("end pulse done", {31'd0, frame_done}, 32'd1);
        step();
        chk("end pulse idle", {30'd0, frame_done, busy}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
